// File: rtl/cordic_pkg.sv
// Shared state encoding, default sizes and a width helper for the CORDIC request scheduler.
package cordic_pkg;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_W     = 6;
   localparam int DEF_ITER  = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STEP,
      ST_CAPT,
      ST_RESP
   } sched_state_e;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cordic_rr_arb.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr (wrapping).
// With CORDIC_SCHED_PRIO_EN defined, requester 0 always wins and rotation covers 1..N_REQ-1.
module cordic_rr_arb
   import cordic_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   always_comb begin
      int cand;
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = 0;
`ifdef CORDIC_SCHED_PRIO_EN
      if (req[0]) begin
         any = 1'b1;
      end else begin
         // Pointer values 1..N_REQ-1 map onto rotation slots 0..N_REQ-2.
         for (int i = 0; i < N_REQ - 1; i++) begin
            cand = 1 + ((((ptr == '0) ? 0 : int'(ptr) - 1) + i) % (N_REQ - 1));
            if (!any && req[cand]) begin
               any = 1'b1;
               idx = ID_W'(cand);
            end
         end
      end
`else
      for (int i = 0; i < N_REQ; i++) begin
         cand = (int'(ptr) + i) % N_REQ;
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = ID_W'(cand);
         end
      end
`endif
      gnt[idx] = any;
   end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one iterative CORDIC core among N_REQ requesters: grant, load, step, capture, respond.
// Optional build macro CORDIC_SCHED_PRIO_EN gives requester 0 strict priority.
module cordic_scheduler
   import cordic_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   parameter  int W     = DEF_W,
   parameter  int ITER  = DEF_ITER,
   localparam int ID_W  = $clog2(N_REQ),
   localparam int IT_W  = clog2_min1(ITER)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_angle,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [ID_W-1:0]    res_id,
   output logic [W-1:0]       res_cos,
   output logic [W-1:0]       res_sin,
   output logic               core_load,
   output logic [W-1:0]       core_angle,
   output logic               core_step,
   output logic [IT_W-1:0]    core_iter,
   input  logic [W-1:0]       core_cos,
   input  logic [W-1:0]       core_sin,
   output logic               busy
);

   sched_state_e    state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [W-1:0]    angle_q, angle_d;
   logic [IT_W-1:0] iter_q, iter_d;
   logic [W-1:0]    res_cos_q, res_cos_d;
   logic [W-1:0]    res_sin_q, res_sin_d;

   logic [N_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]  arb_idx;
   logic             arb_any;
   logic [ID_W-1:0]  ptr_after;
   logic [W-1:0]     angle_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_angle
      assign angle_arr[g] = req_angle[g*W +: W];
   end

   cordic_rr_arb #(.N_REQ(N_REQ)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

`ifdef CORDIC_SCHED_PRIO_EN
   // Priority wins by requester 0 leave the rotation among the others untouched.
   assign ptr_after = (id_q == '0) ? rr_ptr_q :
                      (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
`else
   assign ptr_after = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      id_d       = id_q;
      angle_d    = angle_q;
      iter_d     = iter_q;
      res_cos_d  = res_cos_q;
      res_sin_d  = res_sin_q;
      req_ready  = '0;
      core_load  = 1'b0;
      core_angle = '0;
      core_step  = 1'b0;
      core_iter  = '0;
      res_valid  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Grant is squelched while reset is held so every output reads 0 then.
            if (!RST) req_ready = arb_gnt;
            if (arb_any) begin
               id_d    = arb_idx;
               angle_d = angle_arr[arb_idx];
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            core_load  = 1'b1;
            core_angle = angle_q;
            iter_d     = '0;
            state_d    = ST_STEP;
         end
         ST_STEP: begin
            core_step = 1'b1;
            core_iter = iter_q;
            if (iter_q == IT_W'(ITER - 1)) state_d = ST_CAPT;
            else                           iter_d  = iter_q + 1'b1;
         end
         ST_CAPT: begin
            res_cos_d = core_cos;
            res_sin_d = core_sin;
            state_d   = ST_RESP;
         end
         ST_RESP: begin
            res_valid = 1'b1;
            if (res_ready) begin
               rr_ptr_d = ptr_after;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         id_q      <= '0;
         angle_q   <= '0;
         iter_q    <= '0;
         res_cos_q <= '0;
         res_sin_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop updates from pre-edge values.
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         angle_q   <= angle_d;
         iter_q    <= iter_d;
         res_cos_q <= res_cos_d;
         res_sin_q <= res_sin_d;
      end
   end

   assign res_id  = id_q;
   assign res_cos = res_cos_q;
   assign res_sin = res_sin_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler: table of operations plus reset/glitch/stall sequences.
module tb_cordic_scheduler;

   localparam int N_REQ = 4;
   localparam int W     = 6;
   localparam int ITER  = 6;

   logic             CLK = 1'b0;
   logic             RST;
   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_ready;
   logic [N_REQ*W-1:0] req_angle;
   logic             res_valid;
   logic             res_ready;
   logic [1:0]       res_id;
   logic [W-1:0]     res_cos;
   logic [W-1:0]     res_sin;
   logic             core_load;
   logic [W-1:0]     core_angle;
   logic             core_step;
   logic [2:0]       core_iter;
   logic [W-1:0]     core_cos;
   logic [W-1:0]     core_sin;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [W-1:0] ang_tab [N_REQ];

   typedef struct {
      logic [N_REQ-1:0] valid;
      int               exp_id;
      int               stall;
      bit               glitch;
   } op_t;

   op_t ops [10];

   cordic_scheduler #(.N_REQ(N_REQ), .W(W), .ITER(ITER)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_angle  (req_angle),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_id     (res_id),
      .res_cos    (res_cos),
      .res_sin    (res_sin),
      .core_load  (core_load),
      .core_angle (core_angle),
      .core_step  (core_step),
      .core_iter  (core_iter),
      .core_cos   (core_cos),
      .core_sin   (core_sin),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish within time limit");
      $fatal(1);
   end

   // Core stand-in: its outputs change every cycle, so capture timing is observable.
   function automatic logic [W-1:0] fcos(input int c);
      return W'(c * 3);
   endfunction

   function automatic logic [W-1:0] fsin(input int c);
      return W'(c * 5 + 1);
   endfunction

   function automatic logic [31:0] all_outs();
      return {1'b0, req_ready, res_valid, res_id, res_cos, res_sin,
              core_load, core_angle, core_step, core_iter, busy};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
      core_cos = fcos(cyc);
      core_sin = fsin(cyc);
   endtask

   // Called mid-cycle with the DUT in IDLE; returns mid-cycle in the following IDLE.
   task automatic run_op(input logic [N_REQ-1:0] valid, input int exp_id,
                         input int stall, input bit glitch);
      int c0;
      req_valid = valid;
      #1;
      c0 = cyc;
      check("grant_onehot", 32'(req_ready), 32'(1 << exp_id));
      check("idle_busy", 32'(busy), 32'd0);
      tick();
      req_valid = '0;
      #1;
      check("load", 32'({core_load, core_step, core_angle}), 32'({1'b1, 1'b0, ang_tab[exp_id]}));
      for (int i = 0; i < ITER; i++) begin
         tick();
         req_valid = (glitch && i == 2) ? 4'b0100 : 4'b0000;
         #1;
         check("step", 32'({core_step, core_load, core_iter}), 32'({1'b1, 1'b0, 3'(i)}));
         if (glitch && i == 2) check("busy_no_ready", 32'(req_ready), 32'd0);
      end
      tick();
      req_valid = '0;
      #1;
      check("capt", 32'({core_step, res_valid, busy}), 32'b001);
      tick();
      res_ready = (stall == 0);
      #1;
      check("resp_valid", 32'({res_valid, busy}), 32'b11);
      check("resp_id", 32'(res_id), 32'(exp_id));
      check("resp_cos", 32'(res_cos), 32'(fcos(c0 + ITER + 2)));
      check("resp_sin", 32'(res_sin), 32'(fsin(c0 + ITER + 2)));
      for (int k = 0; k < stall; k++) begin
         tick();
         req_valid = 4'b1111;
         if (k == stall - 1) res_ready = 1'b1;
         #1;
         check("stall_hold", 32'({res_valid, res_id, res_cos, res_sin}),
               32'({1'b1, 2'(exp_id), fcos(c0 + ITER + 2), fsin(c0 + ITER + 2)}));
         check("stall_no_ready", 32'(req_ready), 32'd0);
      end
      tick();
      req_valid = '0;
      res_ready = 1'b0;
      #1;
      check("back_idle", 32'({busy, res_valid}), 32'd0);
   endtask

   initial begin
      ang_tab[0] = 6'b011110;
      ang_tab[1] = 6'h05;
      ang_tab[2] = 6'h2A;
      ang_tab[3] = 6'h33;
`ifdef CORDIC_SCHED_PRIO_EN
      ops[0] = '{4'b0001, 0, 0, 1'b0};
      ops[1] = '{4'b1111, 0, 0, 1'b0};
      ops[2] = '{4'b1110, 1, 0, 1'b0};
      ops[3] = '{4'b1111, 0, 0, 1'b0};
      ops[4] = '{4'b1110, 2, 0, 1'b0};
      ops[5] = '{4'b1010, 3, 0, 1'b0};
      ops[6] = '{4'b1010, 1, 0, 1'b0};
      ops[7] = '{4'b0110, 2, 0, 1'b1};
      ops[8] = '{4'b0011, 0, 0, 1'b0};
      ops[9] = '{4'b0100, 2, 5, 1'b0};
`else
      ops[0] = '{4'b0001, 0, 0, 1'b0};
      ops[1] = '{4'b1111, 1, 0, 1'b0};
      ops[2] = '{4'b1111, 2, 0, 1'b0};
      ops[3] = '{4'b1111, 3, 0, 1'b0};
      ops[4] = '{4'b1111, 0, 0, 1'b0};
      ops[5] = '{4'b0001, 0, 0, 1'b0};
      ops[6] = '{4'b1001, 3, 0, 1'b0};
      ops[7] = '{4'b0110, 1, 0, 1'b1};
      ops[8] = '{4'b0011, 0, 0, 1'b0};
      ops[9] = '{4'b0100, 2, 5, 1'b0};
`endif

      RST       = 1'b1;
      req_valid = 4'b1111;
      res_ready = 1'b1;
      req_angle = {ang_tab[3], ang_tab[2], ang_tab[1], ang_tab[0]};
      core_cos  = '0;
      core_sin  = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_outputs", all_outs(), 32'd0);
      RST = 1'b0;
      #1;
      check("reset_first_grant", 32'(req_ready), 32'b0001);
      req_valid = '0;
      res_ready = 1'b0;
      tick();
      check("reset_idle", all_outs(), 32'd0);

      foreach (ops[n]) run_op(ops[n].valid, ops[n].exp_id, ops[n].stall, ops[n].glitch);

      // Abort in the middle of STEP, then confirm the pointer restarted at requester 0.
      req_valid = 4'b0100;
      #1;
      check("abort_grant", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      repeat (4) tick();
      #1;
      check("abort_at_iter3", 32'({core_step, core_iter}), 32'({1'b1, 3'd3}));
      RST       = 1'b1;
      req_valid = 4'b1111;
      #1;
      check("abort_outputs", all_outs(), 32'd0);
      tick();
      check("abort_held", all_outs(), 32'd0);
      RST = 1'b0;
      #1;
      check("abort_restart_grant", 32'(req_ready), 32'b0001);
      run_op(4'b1111, 0, 0, 1'b0);

      repeat (3) tick();
      check("tail_quiet", 32'({busy, res_valid, core_load, core_step}), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
